// File: rtl/seven_seg_scan_pkg.sv
// rtl/seven_seg_scan_pkg.sv - shared types, segment table and polarity helper for the scan driver
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Active-high patterns, bit 0 = segment a ... bit 6 = segment g; index 15 is leftmost
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_pol(input logic [6:0] pattern, input logic active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - host load side and display pin side of the scan driver
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 2
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    frame_start;

    modport master (
        output digits, digit_en, load,
        input  seg, anode, frame_start
    );

    modport slave (
        input  digits, digit_en, load,
        output seg, anode, frame_start
    );
endinterface

// File: rtl/seven_seg_scan_hex_to_seg.sv
// rtl/seven_seg_scan_hex_to_seg.sv - combinational hex nibble to active-high segment pattern
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);
    assign pattern = SEG_TABLE[nibble];
endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - N-digit multiplexed seven-segment scanner with blanking and double buffering
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS       = 2,
    parameter int DWELL_CYCLES     = 24000,
    parameter int BLANK_CYCLES     = 240,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    seven_seg_scan_if.slave bus
);
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    // With no blanking interval the BLANK state is never entered
    localparam state_t        START_STATE = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
    localparam logic          SEG_LOW     = (SEG_ACTIVE_LOW != 0);
    localparam logic [6:0]    SEG_UNLIT   = seg_pol(7'h00, SEG_LOW);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
        (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    state_t                      state;
    logic [CW-1:0]               cnt;
    logic [IW-1:0]               idx;
    logic [NUM_DIGITS-1:0][3:0]  stage_digits;
    logic [NUM_DIGITS-1:0][3:0]  active_digits;
    logic [NUM_DIGITS-1:0]       stage_en;
    logic [NUM_DIGITS-1:0]       active_en;
    logic                        pending;
    logic                        boundary_q;
    logic                        frame_start_q;
    logic [6:0]                  seg_q;
    logic [NUM_DIGITS-1:0]       anode_q;
    logic [NUM_DIGITS-1:0]       sel;
    logic [6:0]                  cur_pattern;

    wire dwell_done = (state == DRIVE) && (cnt == DWELL_LAST);
    wire blank_done = (state == BLANK) && (cnt == BLANK_LAST);
    // Last cycle of the last digit: the next state is digit 0 of a new frame
    wire boundary   = dwell_done && (idx == IDX_LAST);

    hex_to_seg u_dec (
        .nibble  (active_digits[idx]),
        .pattern (cur_pattern)
    );

    // One-hot select of the digit currently being scanned
    always_comb begin
        sel      = '0;
        sel[idx] = 1'b1;
    end

    // Scan FSM plus registered pins; frame_start is delayed twice so it lines up with digit 0's blank at the pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= START_STATE;
            cnt           <= '0;
            idx           <= '0;
            boundary_q    <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_UNLIT;
            anode_q       <= ANODE_OFF;
        end else begin
            boundary_q    <= boundary;
            frame_start_q <= boundary_q;
            if (state == DRIVE && active_en[idx]) begin
                seg_q   <= seg_pol(cur_pattern, SEG_LOW);
                anode_q <= (ANODE_ACTIVE_LOW != 0) ? ~sel : sel;
            end else begin
                seg_q   <= SEG_UNLIT;
                anode_q <= ANODE_OFF;
            end
            case (state)
                BLANK: begin
                    if (blank_done) begin
                        state <= DRIVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (dwell_done) begin
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        state <= START_STATE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= START_STATE;
            endcase
        end
    end

    // Double buffer: loads stage mid-frame and are promoted only at the frame boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_digits  <= '0;
            stage_en      <= '0;
            active_digits <= '0;
            active_en     <= '0;
            pending       <= 1'b0;
        end else if (boundary && bus.load) begin
            stage_digits  <= bus.digits;
            stage_en      <= bus.digit_en;
            active_digits <= bus.digits;
            active_en     <= bus.digit_en;
            pending       <= 1'b0;
        end else if (boundary && pending) begin
            active_digits <= stage_digits;
            active_en     <= stage_en;
            pending       <= 1'b0;
        end else if (bus.load) begin
            stage_digits <= bus.digits;
            stage_en     <= bus.digit_en;
            pending      <= 1'b1;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.anode       = anode_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - directed self-checking bench for seven_seg_scan
module tb_seven_seg_scan;
    localparam int N    = 4;
    localparam int D    = 8;
    localparam int B    = 2;
    localparam int SLOT = B + D;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    seven_seg_scan_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scan #(
        .NUM_DIGITS       (N),
        .DWELL_CYCLES     (D),
        .BLANK_CYCLES     (B),
        .ANODE_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW   (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Active-low segment patterns for 0..F
    logic [6:0] seg_lo [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Search for frame_start within a cycle budget while the display must stay dark
    task automatic wait_frame(input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            check_eq("dark_seg", bus.seg, 7'h7F);
            check_eq("dark_anode", bus.anode, 4'hF);
            @(negedge clk);
        end
        check_eq("frame_found", found, 1'b1);
    endtask

    // Starting at the negedge where frame_start is visible, check ncyc cycles of pins; optional loads at given offsets
    task automatic check_frame(input logic [15:0] dig, input logic [3:0] en, input int ncyc,
                               input int l1_at, input logic [15:0] l1_d, input logic [3:0] l1_e,
                               input int l2_at, input logic [15:0] l2_d, input logic [3:0] l2_e);
        int         slot;
        int         p;
        logic [3:0] nib;
        logic [6:0] es;
        logic [3:0] ea;
        for (int t = 0; t < ncyc; t++) begin
            bus.load = 1'b0;
            slot = t / SLOT;
            p    = t % SLOT;
            es   = 7'h7F;
            ea   = 4'hF;
            if (p >= B && en[slot]) begin
                nib = dig[slot*4 +: 4];
                es  = seg_lo[nib];
                ea  = ~(4'b0001 << slot);
            end
            check_eq($sformatf("seg d%0h t%0d", dig, t), bus.seg, es);
            check_eq($sformatf("anode d%0h t%0d", dig, t), bus.anode, ea);
            check_eq($sformatf("frame_start d%0h t%0d", dig, t), bus.frame_start, (t == 0));
            if (t == l1_at) begin
                bus.load     = 1'b1;
                bus.digits   = l1_d;
                bus.digit_en = l1_e;
            end
            if (t == l2_at) begin
                bus.load     = 1'b1;
                bus.digits   = l2_d;
                bus.digit_en = l2_e;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.digits   = '0;
        bus.digit_en = '0;
        reset_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_seg", bus.seg, 7'h7F);
        check_eq("reset_anode", bus.anode, 4'hF);
        check_eq("reset_frame_start", bus.frame_start, 1'b0);

        reset_n = 1'b1;
        wait_frame(60);
        // Dark frame; stage 3210 mid-frame
        check_frame(16'h0000, 4'h0, 40, 5, 16'h3210, 4'hF, -1, 16'h0, 4'h0);
        // 3210 all enabled; stage 5432 with slots 0 and 2 disabled
        check_frame(16'h3210, 4'hF, 40, 5, 16'h5432, 4'b1010, -1, 16'h0, 4'h0);
        // Disabled slots keep their time; two loads, only the second must appear
        check_frame(16'h5432, 4'b1010, 40, 15, 16'hFFFF, 4'hF, 25, 16'hDCB7, 4'hF);
        // Load in the boundary cycle goes straight to the next frame
        check_frame(16'hDCB7, 4'hF, 40, 38, 16'hAAAA, 4'hF, -1, 16'h0, 4'h0);
        // Run into digit 2's dwell, then reset asynchronously
        check_frame(16'hAAAA, 4'hF, 25, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        check_eq("pre_reset_seg", bus.seg, 7'h08);
        check_eq("pre_reset_anode", bus.anode, 4'b1011);
        #1 reset_n = 1'b0;
        #1;
        check_eq("async_reset_seg", bus.seg, 7'h7F);
        check_eq("async_reset_anode", bus.anode, 4'hF);
        check_eq("async_reset_frame_start", bus.frame_start, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_frame(60);
        // Active and staging were cleared, so frames stay dark
        check_frame(16'h0000, 4'h0, 40, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        check_frame(16'h0000, 4'h0, 40, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
